// File: rtl/reg16_rr_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg16_rr_arb_if
//  Description : Bundle of requester, consumer and status signals for the
//                reg16_rr_arb shared capture register.
//                  REQ    - per-requester request, bit i = requester i
//                  D      - packed requester words, lane i = D[i*W +: W]
//                  ACK    - one-cycle capture acknowledge (one-hot or zero)
//                  Q      - shared register contents
//                  Q_VLD  - Q holds an unconsumed word
//                  Q_RDY  - consumer accepts Q when Q_VLD & Q_RDY at an edge
//                  GNT_ID - index of the requester whose word is in Q
//                  BUSY   - Q_VLD | (|REQ), status only
//                The master modport is the requester/consumer side; the
//                slave modport is the arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg16_rr_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = 2
) ();

    logic [NREQ-1:0]   REQ;
    logic [NREQ*W-1:0] D;
    logic [NREQ-1:0]   ACK;
    logic [W-1:0]      Q;
    logic              Q_VLD;
    logic              Q_RDY;
    logic [IDW-1:0]    GNT_ID;
    logic              BUSY;

    modport master (
        output REQ,
        output D,
        output Q_RDY,
        input  ACK,
        input  Q,
        input  Q_VLD,
        input  GNT_ID,
        input  BUSY
    );

    modport slave (
        input  REQ,
        input  D,
        input  Q_RDY,
        output ACK,
        output Q,
        output Q_VLD,
        output GNT_ID,
        output BUSY
    );

endinterface
`default_nettype wire

// File: rtl/reg16_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : reg16_rr_arb
//  Description : Round-robin arbiter and loader for one shared W-bit capture
//                register. Up to NREQ requesters present a word with a
//                request line; one is picked fairly, its word is loaded into
//                Q and it receives a one-cycle ACK. Q is then held until the
//                consumer accepts it; consume and refill may share an edge,
//                so one word per cycle is sustained with Q_RDY high.
//  Ports       : CK     - clock, rising edge
//                RST_N  - synchronous active-low reset
//                bus    - reg16_rr_arb_if slave modport (REQ, D, Q_RDY in;
//                         ACK, Q, Q_VLD, GNT_ID, BUSY out)
//  Parameters  : NREQ (2..8), W (word width), IDW (2**IDW >= NREQ)
//  Revision    : 1.0 - initial release
// ============================================================================
module reg16_rr_arb #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = 2
) (
    input  wire logic      CK,
    input  wire logic      RST_N,
    reg16_rr_arb_if.slave  bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // The register has two states and the state bit is exactly Q_VLD.
    localparam logic [0:0]     c_st_empty = 1'b0;
    localparam logic [0:0]     c_st_full  = 1'b1;

    localparam logic [IDW:0]   c_nreq     = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] c_last_id  = IDW'(NREQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]      r_state;
    logic [W-1:0]    r_q;
    logic [IDW-1:0]  r_gnt_id;
    logic [IDW-1:0]  r_ptr;
    logic [NREQ-1:0] r_ack;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic              w_q_vld;
    logic              w_cap;
    logic [NREQ-1:0]   w_elig;
    logic              w_any;
    logic              w_load;
    logic [2*NREQ-1:0] w_elig_dbl;
    logic [2*NREQ-1:0] w_elig_shf;
    logic [NREQ-1:0]   w_rot;
    logic [IDW-1:0]    w_off;
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_sel;
    logic [NREQ-1:0]   w_sel_oh;
    logic [W-1:0]      w_lane_m [NREQ];
    logic [W-1:0]      w_word;

    logic [0:0]        w_state_nxt;
    logic [W-1:0]      w_q_nxt;
    logic [IDW-1:0]    w_gnt_id_nxt;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [NREQ-1:0]   w_ack_nxt;

    assign w_q_vld = (r_state == c_st_full);

    // A slot is free when the register is empty or is being drained on
    // this very edge.
    assign w_cap = ~w_q_vld | bus.Q_RDY;

    // The requester acknowledged this cycle is still holding REQ while it
    // reacts to ACK; masking it prevents capturing the same word twice.
    assign w_elig = bus.REQ & ~r_ack;
    assign w_any  = |w_elig;
    assign w_load = w_cap & w_any;

    // ------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------
    // Rotating the doubled request vector right by PTR puts requester PTR
    // at bit 0, so the wrapped upward search becomes a plain lowest-bit
    // priority encode followed by adding PTR back modulo NREQ.
    assign w_elig_dbl = {w_elig, w_elig};
    assign w_elig_shf = w_elig_dbl >> r_ptr;
    assign w_rot      = w_elig_shf[NREQ-1:0];

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
    end

    // PTR and the offset are both below NREQ, so one conditional
    // subtraction is enough to wrap the sum.
    always_comb begin
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= c_nreq) begin
            w_sum = w_sum - c_nreq;
        end
        w_sel = w_sum[IDW-1:0];
    end

    assign w_sel_oh = NREQ'(1) << w_sel;

    // ------------------------------------------------------------------
    // Word select
    // ------------------------------------------------------------------
    // AND-OR mux driven by the one-hot grant: lanes that are not selected
    // are forced to zero, so garbage or X on idle lanes never reaches Q.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign w_lane_m[i] = {W{w_sel_oh[i]}} & bus.D[i*W +: W];
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_word = w_word | w_lane_m[i];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        w_ack_nxt    = '0;

        if (w_load) begin
            w_state_nxt  = c_st_full;
            w_q_nxt      = w_word;
            w_gnt_id_nxt = w_sel;
            w_ack_nxt    = w_sel_oh;
            w_ptr_nxt    = (w_sel == c_last_id) ? '0 : w_sel + IDW'(1);
        end else if (w_cap) begin
            // Free slot but nobody eligible: a word being consumed leaves
            // the register empty; an empty register stays empty.
            w_state_nxt = c_st_empty;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (!RST_N) begin
            r_state  <= c_st_empty;
            r_q      <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            r_ack    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_ptr    <= w_ptr_nxt;
            r_ack    <= w_ack_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.Q      = r_q;
    assign bus.Q_VLD  = w_q_vld;
    assign bus.GNT_ID = r_gnt_id;
    assign bus.ACK    = r_ack;
    assign bus.BUSY   = w_q_vld | (|bus.REQ);

endmodule
`default_nettype wire

// File: tb/tb_reg16_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg16_rr_arb
//  Description : Self-checking bench for reg16_rr_arb. Directed scenarios
//                for reset, single request, fairness, back-pressure, pointer
//                wrap and mid-operation reset, followed by randomized
//                requester/consumer traffic compared every cycle against a
//                behavioural model of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg16_rr_arb;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    logic CK    = 1'b0;
    logic RST_N = 1'b0;

    always #5 CK = ~CK;

    reg16_rr_arb_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    reg16_rr_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .CK    (CK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Stimulus
    logic [NREQ-1:0] req = '0;
    logic [W-1:0]    lane [NREQ];
    logic            rdy = 1'b0;

    assign bus.REQ   = req;
    assign bus.Q_RDY = rdy;
    for (genvar g = 0; g < NREQ; g++) begin : g_drv
        assign bus.D[g*W +: W] = lane[g];
    end

    // Reference model: held word, valid flag, last acknowledged requester
    // (-1 when none), grant index and fairness pointer.
    int m_q     = 0;
    bit m_vld   = 1'b0;
    int m_ack   = -1;
    int m_gnt   = 0;
    int m_ptr   = 0;
    bit m_known = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: check BUSY on the current inputs, advance the model by the
    // arbitration rules, let the edge happen and compare all outputs.
    task automatic step();
        int sel;
        int idx;
        bit cap;
        #1;
        if (m_known) begin
            check("busy", 32'(bus.BUSY), 32'(m_vld | (|req)));
        end
        if (!RST_N) begin
            m_q = 0; m_vld = 1'b0; m_ack = -1; m_gnt = 0; m_ptr = 0;
            m_known = 1'b1;
        end else begin
            cap = !m_vld || rdy;
            sel = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (sel < 0 && req[idx] && idx != m_ack) sel = idx;
            end
            if (cap && sel >= 0) begin
                m_q   = int'(lane[sel]);
                m_vld = 1'b1;
                m_gnt = sel;
                m_ack = sel;
                m_ptr = (sel + 1) % NREQ;
            end else begin
                if (cap) m_vld = 1'b0;
                m_ack = -1;
            end
        end
        @(posedge CK);
        #1;
        check("q",      32'(bus.Q),      32'(m_q));
        check("q_vld",  32'(bus.Q_VLD),  32'(m_vld));
        check("ack",    32'(bus.ACK),    (m_ack < 0) ? 32'd0 : (32'd1 << m_ack));
        check("gnt_id", 32'(bus.GNT_ID), 32'(m_gnt));
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) lane[i] = W'((i + 1) * 16'h1111);

        // 1. Reset with all requests high
        req = 4'b1111; rdy = 1'b1; RST_N = 1'b0;
        step();
        step();
        check("t1_rst_q",   32'(bus.Q),     32'h0);
        check("t1_rst_vld", 32'(bus.Q_VLD), 32'h0);
        check("t1_rst_ack", 32'(bus.ACK),   32'h0);
        RST_N = 1'b1;
        step();
        check("t1_first_gnt", 32'(bus.GNT_ID), 32'd0);
        check("t1_first_q",   32'(bus.Q),      32'h1111);

        // 3. Fairness: rotating grants, one capture per edge
        for (int k = 1; k < 8; k++) begin
            step();
            check("t3_gnt", 32'(bus.GNT_ID), 32'(k % 4));
            check("t3_ack", 32'(bus.ACK),    32'd1 << (k % 4));
            check("t3_q",   32'(bus.Q),      32'(((k % 4) + 1) * 32'h1111));
        end

        // 2. Single request into an empty register, held under back-pressure
        req = '0; rdy = 1'b1;
        step();
        check("t2_empty", 32'(bus.Q_VLD), 32'h0);
        req = 4'b0100; lane[2] = 16'hA5C3; rdy = 1'b0;
        step();
        check("t2_q",   32'(bus.Q),      32'hA5C3);
        check("t2_vld", 32'(bus.Q_VLD),  32'h1);
        check("t2_gnt", 32'(bus.GNT_ID), 32'd2);
        check("t2_ack", 32'(bus.ACK),    32'h4);
        req = '0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("t2_hold_q",   32'(bus.Q),   32'hA5C3);
            check("t2_hold_ack", 32'(bus.ACK), 32'h0);
        end
        rdy = 1'b1;
        step();
        check("t2_drained", 32'(bus.Q_VLD), 32'h0);

        // 4. Back-pressure then consume-and-refill on one edge
        lane[0] = 16'h0A0A; lane[1] = 16'h0B0B;
        req = 4'b0011; rdy = 1'b0;
        step();
        check("t4_q0", 32'(bus.Q), 32'h0A0A);
        req = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_hold_q",   32'(bus.Q),   32'h0A0A);
            check("t4_hold_ack", 32'(bus.ACK), 32'h0);
        end
        rdy = 1'b1;
        step();
        check("t4_q1",   32'(bus.Q),     32'h0B0B);
        check("t4_vld1", 32'(bus.Q_VLD), 32'h1);
        req = '0;
        step();

        // 5. Pointer wrap from 3 and ACK masking
        req = 4'b0100;
        step();
        check("t5_gnt2", 32'(bus.GNT_ID), 32'd2);
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_alt", 32'(bus.GNT_ID), (k % 2 == 0) ? 32'd0 : 32'd2);
        end
        req = '0;
        step();

        // 6. Reset while FULL with a pending request
        rdy = 1'b0; req = 4'b1000; lane[3] = 16'hBEEF;
        step();
        step();
        check("t6_full_q", 32'(bus.Q), 32'hBEEF);
        RST_N = 1'b0;
        step();
        check("t6_rst_q",   32'(bus.Q),     32'h0);
        check("t6_rst_vld", 32'(bus.Q_VLD), 32'h0);
        RST_N = 1'b1;
        step();
        check("t6_regrant", 32'(bus.GNT_ID), 32'd3);
        check("t6_ack",     32'(bus.ACK),    32'h8);
        req = '0; rdy = 1'b1;
        step();

        // Randomized traffic following the requester protocol
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && m_ack == i) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    lane[i] = W'($urandom);
                end else if (!req[i]) begin
                    if ($urandom_range(2, 0) == 0) req[i] = 1'b1;
                    lane[i] = W'($urandom);
                end
            end
            rdy   = ($urandom_range(3, 0) != 0);
            RST_N = ($urandom_range(149, 0) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
